// File: rtl/pool_1st.sv
// 2x2 stride-2 signed max pooling over a stream of conv rows, with row/channel tracking.
// Optional build macro POOL_1ST_RELU_EN clamps every input lane to max(x,0) before pooling.
module pool_1st #(
    parameter int LANES  = 40,
    parameter int DW     = 8,
    parameter int ROWS   = 40,
    parameter int CH_NUM = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sta,
    input  logic                          valid_i,
    input  logic [LANES*DW-1:0]           conv_i,
    output logic [(LANES/2)*DW-1:0]       pool_o,
    output logic                          valid_o,
    output logic [$clog2(ROWS/2)-1:0]     row_o,
    output logic [$clog2(CH_NUM)-1:0]     ch_o,
    output logic                          done_o
);

    localparam int IW  = LANES * DW;
    localparam int OW  = (LANES / 2) * DW;
    localparam int RCW = $clog2(ROWS);
    localparam int RW  = $clog2(ROWS / 2);
    localparam int CW  = $clog2(CH_NUM);

    localparam logic [RCW-1:0] ROW_LAST = RCW'(ROWS - 1);
    localparam logic [CW-1:0]  CH_LAST  = CW'(CH_NUM - 1);

    logic [RCW-1:0] row_cnt;
    logic [CW-1:0]  ch_cnt;
    logic [IW-1:0]  row_buf;
    logic [IW-1:0]  conv_c;
    logic [OW-1:0]  pool_next;
    logic           accept;

    assign accept = sta & valid_i;

    function automatic logic [DW-1:0] smax(input logic signed [DW-1:0] a,
                                           input logic signed [DW-1:0] b);
        return (a > b) ? a : b;
    endfunction

`ifdef POOL_1ST_RELU_EN
    // Clamping at the input means the buffered row is already non-negative.
    always_comb begin
        conv_c = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            conv_c[k*DW +: DW] = conv_i[k*DW+DW-1] ? '0 : conv_i[k*DW +: DW];
        end
    end
`else
    assign conv_c = conv_i;
`endif

    always_comb begin
        pool_next = '0;
        for (int unsigned j = 0; j < LANES / 2; j++) begin
            pool_next[j*DW +: DW] = smax(smax(row_buf[(2*j)*DW +: DW], row_buf[(2*j+1)*DW +: DW]),
                                         smax(conv_c[(2*j)*DW +: DW],  conv_c[(2*j+1)*DW +: DW]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pool_o  <= '0;
            valid_o <= 1'b0;
            row_o   <= '0;
            ch_o    <= '0;
            done_o  <= 1'b0;
            row_cnt <= '0;
            ch_cnt  <= '0;
            row_buf <= '0;
        end else if (!sta) begin
            // Counters restart so the next accepted beat is row 0; a stale buffered row is never used.
            valid_o <= 1'b0;
            done_o  <= 1'b0;
            row_cnt <= '0;
            ch_cnt  <= '0;
        end else begin
            valid_o <= 1'b0;
            done_o  <= 1'b0;
            if (accept) begin
                if (!row_cnt[0]) begin
                    row_buf <= conv_c;
                end else begin
                    pool_o  <= pool_next;
                    valid_o <= 1'b1;
                    row_o   <= RW'(row_cnt >> 1);
                    ch_o    <= ch_cnt;
                    done_o  <= (row_cnt == ROW_LAST) && (ch_cnt == CH_LAST);
                end
                if (row_cnt == ROW_LAST) begin
                    row_cnt <= '0;
                    ch_cnt  <= (ch_cnt == CH_LAST) ? '0 : ch_cnt + 1'b1;
                end else begin
                    row_cnt <= row_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pool_1st.sv
// Directed self-checking bench for pool_1st; honours POOL_1ST_RELU_EN when defined.
module tb_pool_1st;

    localparam int LANES  = 40;
    localparam int DW     = 8;
    localparam int ROWS   = 40;
    localparam int CH_NUM = 32;
    localparam int IW     = LANES * DW;
    localparam int OW     = (LANES / 2) * DW;
    localparam int BEATS  = ROWS * CH_NUM;

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b0;
    logic                        sta = 1'b0;
    logic                        valid_i = 1'b0;
    logic [IW-1:0]               conv_i = '0;
    logic [OW-1:0]               pool_o;
    logic                        valid_o;
    logic [$clog2(ROWS/2)-1:0]   row_o;
    logic [$clog2(CH_NUM)-1:0]   ch_o;
    logic                        done_o;

    int n_assert = 0;
    int n_fail   = 0;
    int pulses   = 0;
    int dones    = 0;

    pool_1st #(.LANES(LANES), .DW(DW), .ROWS(ROWS), .CH_NUM(CH_NUM)) dut (
        .clk(clk), .rst_n(rst_n), .sta(sta), .valid_i(valid_i), .conv_i(conv_i),
        .pool_o(pool_o), .valid_o(valid_o), .row_o(row_o), .ch_o(ch_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [IW-1:0] obs, input logic [IW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply inputs at a falling edge; return at the next falling edge, after the rising edge consumed them.
    task automatic step(input logic v, input logic [IW-1:0] d);
        valid_i = v;
        conv_i  = d;
        @(negedge clk);
    endtask

    function automatic logic [IW-1:0] row4(input logic [7:0] l0, l1, l2, l3);
        logic [IW-1:0] v;
        v = '0;
        v[0*DW +: DW] = l0;
        v[1*DW +: DW] = l1;
        v[2*DW +: DW] = l2;
        v[3*DW +: DW] = l3;
        return v;
    endfunction

    function automatic logic [OW-1:0] pool2(input logic [7:0] l0, l1);
        logic [OW-1:0] v;
        v = '0;
        v[0*DW +: DW] = l0;
        v[1*DW +: DW] = l1;
        return v;
    endfunction

    initial begin
        logic [7:0]    p7;
        logic [OW-1:0] neg_exp;

        // Reset held, then released, with sta low and valid_i toggling
        for (int i = 0; i < 8; i++) begin
            if (i == 4) rst_n = 1'b1;
            step(i[0], '1);
            chk("idle_valid", valid_o, 0);
            chk("idle_pool", pool_o, 0);
            chk("idle_row", row_o, 0);
            chk("idle_ch", ch_o, 0);
            chk("idle_done", done_o, 0);
        end

        // Basic pool
        sta = 1'b1;
        step(1'b1, row4(8'h01, 8'h05, 8'h80, 8'h7F));
        chk("basic_even_valid", valid_o, 0);
        step(1'b1, row4(8'h03, 8'h02, 8'hFF, 8'h10));
        chk("basic_valid", valid_o, 1);
        chk("basic_pool", pool_o, pool2(8'h05, 8'h7F));
        chk("basic_row", row_o, 0);
        chk("basic_ch", ch_o, 0);
        chk("basic_done", done_o, 0);
        step(1'b0, '1);
        chk("basic_pulse_end", valid_o, 0);
        chk("basic_hold", pool_o, pool2(8'h05, 8'h7F));

        // Negative-only window
`ifdef POOL_1ST_RELU_EN
        neg_exp = pool2(8'h00, 8'h00);
`else
        neg_exp = pool2(8'hFE, 8'h00);
`endif
        step(1'b1, row4(8'hF0, 8'hF1, 8'h00, 8'h00));
        chk("neg_even_valid", valid_o, 0);
        step(1'b1, row4(8'hF2, 8'hFE, 8'h00, 8'h00));
        chk("neg_valid", valid_o, 1);
        chk("neg_pool", pool_o, neg_exp);
        chk("neg_row", row_o, 1);

        // sta low: counters clear, pool_o holds
        sta = 1'b0;
        step(1'b1, '1);
        chk("sta_low_valid", valid_o, 0);
        chk("sta_low_hold", pool_o, neg_exp);
        sta = 1'b1;

        // Full frame, continuous beats; even rows all -128, odd rows all p[6:0]
        for (int i = 0; i < BEATS; i++) begin
            p7 = 8'((i / 2) % 128);
            if (i % 2 == 1) step(1'b1, {LANES{p7}});
            else            step(1'b1, {LANES{8'h80}});
            if (valid_o) pulses++;
            if (done_o)  dones++;
            if (i % 2 == 1) begin
                chk("frame_valid", valid_o, 1);
                chk("frame_pool", pool_o, {(LANES/2){p7}});
                chk("frame_row", row_o, (i % ROWS) / 2);
                chk("frame_ch", ch_o, i / ROWS);
                chk("frame_done", done_o, (i == BEATS - 1) ? 1 : 0);
            end else begin
                chk("frame_even_valid", valid_o, 0);
                chk("frame_even_done", done_o, 0);
            end
        end
        chk("frame_pulses", pulses, BEATS / 2);
        chk("frame_dones", dones, 1);

        // Next frame starts immediately at row 0, channel 0
        step(1'b1, row4(8'h10, 8'h00, 8'h00, 8'h00));
        step(1'b1, row4(8'h00, 8'h20, 8'h00, 8'h00));
        chk("wrap_valid", valid_o, 1);
        chk("wrap_row", row_o, 0);
        chk("wrap_ch", ch_o, 0);
        chk("wrap_done", done_o, 0);
        chk("wrap_pool", pool_o, pool2(8'h20, 8'h00));

        // Gapped input 1,0,0,1; gap data must not be captured
        step(1'b1, row4(8'h11, 8'h30, 8'h00, 8'h00));
        chk("gap_b0_valid", valid_o, 0);
        step(1'b0, row4(8'h7F, 8'h7F, 8'h7F, 8'h7F));
        chk("gap_g0_valid", valid_o, 0);
        step(1'b0, row4(8'h7F, 8'h7F, 8'h7F, 8'h7F));
        chk("gap_g1_valid", valid_o, 0);
        step(1'b1, row4(8'h22, 8'h00, 8'h00, 8'h00));
        chk("gap_valid", valid_o, 1);
        chk("gap_row", row_o, 1);
        chk("gap_ch", ch_o, 0);
        chk("gap_pool", pool_o, pool2(8'h30, 8'h00));
        step(1'b0, '0);
        chk("gap_pulse_end", valid_o, 0);

        // Abort via sta after rows 0..5
        sta = 1'b0;
        step(1'b0, '0);
        sta = 1'b1;
        for (int r = 0; r < 6; r++) step(1'b1, row4(8'h70, 8'h70, 8'h70, 8'h70));
        sta = 1'b0;
        step(1'b1, row4(8'h7F, 8'h7F, 8'h7F, 8'h7F));
        chk("abort_sta_valid", valid_o, 0);
        sta = 1'b1;
        step(1'b1, row4(8'h05, 8'h00, 8'h00, 8'h00));
        chk("abort_sta_even_valid", valid_o, 0);
        step(1'b1, row4(8'h00, 8'h06, 8'h00, 8'h00));
        chk("abort_sta_valid_o", valid_o, 1);
        chk("abort_sta_row", row_o, 0);
        chk("abort_sta_ch", ch_o, 0);
        chk("abort_sta_pool", pool_o, pool2(8'h06, 8'h00));

        // Abort via rst_n after rows 0..6 (row 6 left buffered)
        sta = 1'b0;
        step(1'b0, '0);
        sta = 1'b1;
        for (int r = 0; r < 7; r++) step(1'b1, row4(8'h70, 8'h70, 8'h70, 8'h70));
        rst_n = 1'b0;
        #1;
        chk("abort_rst_async_valid", valid_o, 0);
        chk("abort_rst_async_pool", pool_o, 0);
        chk("abort_rst_async_row", row_o, 0);
        chk("abort_rst_async_ch", ch_o, 0);
        step(1'b0, '0);
        rst_n = 1'b1;
        step(1'b1, row4(8'h05, 8'h00, 8'h00, 8'h00));
        chk("abort_rst_even_valid", valid_o, 0);
        step(1'b1, row4(8'h00, 8'h06, 8'h00, 8'h00));
        chk("abort_rst_valid_o", valid_o, 1);
        chk("abort_rst_row", row_o, 0);
        chk("abort_rst_ch", ch_o, 0);
        chk("abort_rst_pool", pool_o, pool2(8'h06, 8'h00));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
